// File: rtl/dino_motion_pkg.sv
// -----------------------------------------------------------------------------
// dino_motion_pkg
// Shared definitions for the dino game datapath: the player FSM state codes,
// the screen/sprite geometry used by display, obstacle and collision blocks,
// and a small helper that classifies airborne states.
// No ports (package).
// -----------------------------------------------------------------------------
package dino_motion_pkg;

    // Player FSM state codes; the numeric values are visible on the state port.
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_RISE = 2'd1,
        ST_FALL = 2'd2,
        ST_DUCK = 2'd3
    } dino_state_t;

    // Screen and sprite geometry shared with the display controller.
    localparam int unsigned GROUND_LINE = 335;
    localparam int unsigned SPRITE_H    = 60;
    localparam int unsigned SPRITE_W    = 60;
    localparam int unsigned SCREEN_W    = 640;
    localparam int unsigned SCREEN_H    = 480;

    // Sprite top-left y when the dino stands on the ground line.
    localparam int unsigned DEF_GROUND_Y = GROUND_LINE - SPRITE_H;

    // True while the dino is off the ground (rising or falling).
    function automatic logic stateIsAirborne(input dino_state_t s);
        return (s == ST_RISE) || (s == ST_FALL);
    endfunction

endpackage

// File: rtl/dino_motion_frame_tick_edge.sv
// -----------------------------------------------------------------------------
// frame_tick_edge
// Registered rising-edge detector. The display timing holds screenEnd high for
// several clocks; this turns it into a single-clock update strobe per frame.
// Ports:
//   i_clk       system clock
//   i_reset     synchronous active-high reset
//   i_frameTick frame tick level from the display timing
//   o_upd       one-clock strobe, one cycle after the tick rises
// -----------------------------------------------------------------------------
module frame_tick_edge (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_frameTick,
    output logic o_upd
);

    logic r_tickPrev;
    logic r_upd;

    // Remember the previous tick level and register the 0->1 transition so the
    // strobe is glitch-free and lasts exactly one clock however long the tick
    // stays high.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tickPrev <= 1'b0;
            r_upd      <= 1'b0;
        end else begin
            r_tickPrev <= i_frameTick;
            r_upd      <= i_frameTick & ~r_tickPrev;
        end
    end

    assign o_upd = r_upd;

endmodule

// File: rtl/dino_motion.sv
// -----------------------------------------------------------------------------
// dino_motion
// Per-frame player physics for the dino game. Once per video frame it samples
// the up/down buttons and advances a run/rise/fall/duck state machine with
// integer gravity, producing sprite coordinates for the VGA display controller
// that stay stable for the whole frame.
// Ports:
//   clk        100 MHz system clock
//   reset      synchronous active-high reset
//   frame_tick screenEnd from display timing (may be high for several clocks)
//   up         jump button level
//   down       duck / fast-fall button level
//   dino_x     sprite x (fixed)
//   dino_y     sprite y, 10-bit value zero-extended
//   airborne   high in RISE or FALL
//   ducking    high in DUCK
//   state      current FSM state code
// -----------------------------------------------------------------------------
module dino_motion
    import dino_motion_pkg::*;
#(
    parameter int unsigned DINO_X   = 50,
    parameter int unsigned GROUND_Y = DEF_GROUND_Y,
    parameter int unsigned MIN_Y    = 0,
    parameter int unsigned JUMP_VEL = 12,
    parameter int unsigned GRAVITY  = 1,
    parameter int unsigned MAX_FALL = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        up,
    input  logic        down,
    output logic [31:0] dino_x,
    output logic [31:0] dino_y,
    output logic        airborne,
    output logic        ducking,
    output logic [1:0]  state
);

    localparam logic [9:0] L_GROUND_Y = 10'(GROUND_Y);
    localparam logic [9:0] L_MIN_Y    = 10'(MIN_Y);
    localparam logic [7:0] L_JUMP_VEL = 8'(JUMP_VEL);
    localparam logic [7:0] L_GRAVITY  = 8'(GRAVITY);
    localparam logic [7:0] L_MAX_FALL = 8'(MAX_FALL);

    dino_state_t r_state;
    logic [9:0]  r_y;
    logic [7:0]  r_vy;
    logic        r_armed;

    dino_state_t w_nextState;
    logic [9:0]  w_nextY;
    logic [7:0]  w_nextVy;
    logic        w_nextArmed;

    logic               w_upd;
    logic signed [32:0] w_ceilDiff;
    logic signed [32:0] w_ceilMin;
    logic [10:0]        w_fallSum;
    logic [8:0]         w_fallVy;

    frame_tick_edge u_tickEdge (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_frameTick (frame_tick),
        .o_upd       (w_upd)
    );

    // Ceiling test is done signed so a large upward speed near the top cannot
    // wrap y around to a huge value.
    assign w_ceilDiff = $signed({23'd0, r_y}) - $signed({25'd0, r_vy});
    assign w_ceilMin  = $signed({23'd0, L_MIN_Y});

    // Candidate landing position and next falling speed, widened by one bit so
    // neither can overflow before the clamp/limit is applied.
    assign w_fallSum = {1'b0, r_y} + {3'd0, r_vy};
    assign w_fallVy  = {1'b0, r_vy} + {1'b0, L_GRAVITY}
                     + (down ? {1'b0, L_GRAVITY} : 9'd0);

    // State register: all player state moves together, and reset wins over any
    // update that happens to coincide with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_y     <= L_GROUND_Y;
            r_vy    <= 8'd0;
            r_armed <= 1'b1;
        end else begin
            r_state <= w_nextState;
            r_y     <= w_nextY;
            r_vy    <= w_nextVy;
            r_armed <= w_nextArmed;
        end
    end

    // Next-state and physics. Everything holds between frames; on the update
    // strobe the buttons are sampled and one physics step is taken. jump_armed
    // re-arms whenever up is seen released, so a held button gives one jump.
    always_comb begin
        w_nextState = r_state;
        w_nextY     = r_y;
        w_nextVy    = r_vy;
        w_nextArmed = r_armed;

        if (w_upd && !up) begin
            w_nextArmed = 1'b1;
        end

        case (r_state)
            ST_RUN: begin
                if (w_upd) begin
                    if (down) begin
                        w_nextState = ST_DUCK;
                    end else if (up && r_armed) begin
                        w_nextState = ST_RISE;
                        w_nextVy    = L_JUMP_VEL;
                        w_nextArmed = 1'b0;
                    end
                end
            end

            ST_DUCK: begin
                if (w_upd) begin
                    w_nextY = L_GROUND_Y;
                    if (!down) begin
                        w_nextState = ST_RUN;
                    end
                end
            end

            ST_RISE: begin
                if (w_upd) begin
                    if (down) begin
                        w_nextState = ST_FALL;
                        w_nextVy    = 8'd0;
                    end else if (w_ceilDiff < w_ceilMin) begin
                        w_nextY     = L_MIN_Y;
                        w_nextState = ST_FALL;
                        w_nextVy    = 8'd0;
                    end else begin
                        w_nextY = r_y - {2'd0, r_vy};
                        if (r_vy <= L_GRAVITY) begin
                            w_nextState = ST_FALL;
                            w_nextVy    = 8'd0;
                        end else begin
                            w_nextVy = r_vy - L_GRAVITY;
                        end
                    end
                end
            end

            ST_FALL: begin
                if (w_upd) begin
                    if (w_fallSum >= {1'b0, L_GROUND_Y}) begin
                        w_nextY     = L_GROUND_Y;
                        w_nextVy    = 8'd0;
                        w_nextState = down ? ST_DUCK : ST_RUN;
                    end else begin
                        w_nextY  = w_fallSum[9:0];
                        w_nextVy = (w_fallVy > {1'b0, L_MAX_FALL})
                                 ? L_MAX_FALL : w_fallVy[7:0];
                    end
                end
            end

            default: begin
                w_nextState = ST_RUN;
                w_nextY     = L_GROUND_Y;
                w_nextVy    = 8'd0;
            end
        endcase
    end

    // Outputs are pure decodes of registered state, so they only move on the
    // clock after an update and are stable for the rest of the frame.
    always_comb begin
        dino_x   = 32'(DINO_X);
        dino_y   = {22'd0, r_y};
        airborne = stateIsAirborne(r_state);
        ducking  = (r_state == ST_DUCK);
        state    = r_state;
    end

endmodule
